// File: rtl/nk_board_game.sv
// rtl/nk_board_game.sv - N x N two-side board game core with multi-cycle K-in-a-row scan.
// Optional turn alternation check is compiled in with `define TURN_ENFORCE_EN.
module nk_board_game #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              player_move,
    input  logic              computer_move,
    input  logic [AW-1:0]     player_address,
    input  logic [AW-1:0]     computer_address,
    output logic [2*N*N-1:0]  board,
    output logic              busy,
    output logic              illegal_move,
    output logic              win,
    output logic              tie,
    output logic [1:0]        winner
);

    localparam int CELLS = N * N;
    localparam int FW    = $clog2(CELLS + 1);
    localparam int IW    = $clog2(CELLS);

    typedef enum logic [1:0] {IDLE, SCAN, OVER} state_t;

    state_t              state_q;
    logic [2*CELLS-1:0]  board_q;
    logic [IW-1:0]       idx_q;
    logic [FW-1:0]       fill_q;
    logic [1:0]          mover_q;
    logic                match_q;
    logic                pm_q, cm_q;
    logic                busy_q, illegal_q, win_q, tie_q;
    logic [1:0]          winner_q;

    // Off-board coordinates read as 11, which never equals a mover code.
    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int r, input int c);
        if (r < 0 || r >= N || c < 0 || c >= N)
            return 2'b11;
        return b[2*(r*N+c) +: 2];
    endfunction

    function automatic logic run_at(input logic [2*CELLS-1:0] b, input int r, input int c,
                                    input int dr, input int dc, input logic [1:0] code);
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < K; j++)
            if (cell_at(b, r + dr*j, c + dc*j) != code)
                ok = 1'b0;
        return ok;
    endfunction

    logic          preq, creq, any_req, turn_bad, req_ok, hit_d;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_code;
    int            req_idx, scan_row, scan_col;

    assign preq     = player_move & ~pm_q;
    assign creq     = computer_move & ~cm_q;
    assign any_req  = preq | creq;
    assign req_addr = preq ? player_address : computer_address;
    assign req_code = preq ? 2'b01 : 2'b10;
    assign req_idx  = int'(req_addr);

`ifdef TURN_ENFORCE_EN
    logic [1:0] last_q;
    assign turn_bad = (last_q == req_code);
`else
    assign turn_bad = 1'b0;
`endif

    assign req_ok = !(preq && creq) && (req_idx < CELLS) && !turn_bad &&
                    (cell_at(board_q, req_idx / N, req_idx % N) == 2'b00);

    assign scan_row = int'(idx_q) / N;
    assign scan_col = int'(idx_q) % N;
    assign hit_d    = run_at(board_q, scan_row, scan_col, 0,  1, mover_q) |
                      run_at(board_q, scan_row, scan_col, 1,  0, mover_q) |
                      run_at(board_q, scan_row, scan_col, 1,  1, mover_q) |
                      run_at(board_q, scan_row, scan_col, 1, -1, mover_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            board_q   <= '0;
            idx_q     <= '0;
            fill_q    <= '0;
            mover_q   <= 2'b00;
            match_q   <= 1'b0;
            pm_q      <= 1'b0;
            cm_q      <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
            win_q     <= 1'b0;
            tie_q     <= 1'b0;
            winner_q  <= 2'b00;
`ifdef TURN_ENFORCE_EN
            last_q    <= 2'b00;
`endif
        end else begin
            pm_q      <= player_move;
            cm_q      <= computer_move;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        if (req_ok) begin
                            board_q[2*req_idx +: 2] <= req_code;
                            fill_q  <= fill_q + FW'(1);
                            mover_q <= req_code;
`ifdef TURN_ENFORCE_EN
                            last_q  <= req_code;
`endif
                            idx_q   <= '0;
                            match_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= SCAN;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (any_req)
                        illegal_q <= 1'b1;
                    // Final index folds in its own hit so the result lands on the same edge.
                    if (idx_q == IW'(CELLS - 1)) begin
                        busy_q <= 1'b0;
                        if (match_q | hit_d) begin
                            win_q    <= 1'b1;
                            winner_q <= mover_q;
                            state_q  <= OVER;
                        end else if (fill_q == FW'(CELLS)) begin
                            tie_q   <= 1'b1;
                            state_q <= OVER;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        match_q <= match_q | hit_d;
                    end
                end
                default: begin
                    if (any_req)
                        illegal_q <= 1'b1;
                end
            endcase
        end
    end

    assign board        = board_q;
    assign busy         = busy_q;
    assign illegal_move = illegal_q;
    assign win          = win_q;
    assign tie          = tie_q;
    assign winner       = winner_q;

endmodule

// File: doc/nk_board_game.md
# nk_board_game

Parametrised successor to the 3×3 tic-tac-toe core. It holds an N×N board for two sides (player, computer) and accepts one move per request edge, rejecting illegal moves. After each accepted move it runs a multi-cycle K-in-a-row scan, then reports win, winner or tie. It sits between the move-input logic (buttons or the computer move generator) and the LED/display driver.

## Interface
- `N`, default 3: board side; cells 0..N*N-1, row-major (cell = row*N + col).
- `K`, default 3: run length that wins; 2 ≤ K ≤ N.
- `AW`, default 4: address width; requires 2^AW ≥ N*N.
- `clk` in, 1: system clock, rising edge.
- `rstn` in, 1: asynchronous, active-low reset.
- `player_move` in, 1: player move request; acted on at its rising edge.
- `computer_move` in, 1: computer move request; acted on at its rising edge.
- `player_address` in, AW: player target cell.
- `computer_address` in, AW: computer target cell.
- `board` out, 2*N*N: cell i at bits [2i+1:2i]; 00 empty, 01 player, 10 computer.
- `busy` out, 1: scan in progress.
- `illegal_move` out, 1: one-cycle pulse when a request is rejected.
- `win` out, 1: sticky; a K-run exists.
- `tie` out, 1: sticky; board full with no win.
- `winner` out, 2: 01 player, 10 computer, 00 none.

## Operation
- Request detection: each move input is registered once. A request is the edge where the registered copy is 0 and the input is 1. A level held high counts once.
- FSM states:
  - IDLE: accept moves.
  - SCAN: check cells 0..N*N-1, one start cell per clock.
  - OVER: game finished.
- Per scanned start cell, check 4 directions combinationally: right, down, down-right, down-left. Each direction tests K cells, with bounds checks on row and column; out-of-board runs do not match. A run matches if all K cells equal the mover's code.
- IDLE request handling:
  - Rejected (`illegal_move` pulses) if any of:
    - both requests occur on the same edge;
    - address ≥ N*N;
    - target cell is not 00;
    - turn violation (see Configuration).
  - Otherwise: write the cell, increment the fill counter (width clog2(N*N+1)), latch the mover, go to SCAN with index 0.
- A request in SCAN or OVER is rejected with an `illegal_move` pulse. The board is unchanged.
- End of scan, after index N*N-1:
  - Any match: set `win`, set `winner` to the mover code, go to OVER.
  - Else, fill counter = N*N: set `tie`, go to OVER.
  - Else: go to IDLE.
- OVER holds until reset. Only `rstn` starts a new game.

## Timing
- Reset (async assert): `board` all 0, `busy` 0, `illegal_move` 0, `win` 0, `tie` 0, `winner` 00, state IDLE, fill 0, edge registers 0, last-mover none.
- Accepting edge A: cell visible and `busy`=1 after A.
- Scan edges A+1..A+N*N evaluate indices 0..N*N-1.
- After edge A+N*N: `busy`=0, and `win`/`tie` are valid. Latency is N*N cycles; 9 for N=3.
- `illegal_move` is high for exactly the one cycle after the offending edge.
- Reset mid-SCAN aborts immediately to the reset state. No partial result appears.
- A request edge that coincides with the last scan edge is rejected. Next-move acceptance begins the cycle after `busy` falls.

## Configuration
- `TURN_ENFORCE_EN` defined:
  - The first move may be by either side; after that, sides must alternate.
  - A same-side repeat is illegal: `illegal_move` pulses and the board is unchanged.
  - A rejected move does not change the last-mover record.
- `TURN_ENFORCE_EN` undefined:
  - No turn check; either side may move repeatedly.
  - Last-mover logic is absent.

## Test plan
- Reset, then check outputs: `board`=0, `win`=`tie`=0, `winner`=00, `busy`=0, `illegal_move`=0.
- N=3, K=3, macro off. Player 4, computer 3, player 0, computer 8, player 1, computer 7, player 2. Required: `win`=1 and `winner`=01 exactly 9 cycles after the last accept; a further move gives an `illegal_move` pulse.
- N=3, K=3, macro off. Computer 0, player 1, player 2, player 3, computer 4, computer 5, player 6, computer 7, player 8. Required: `tie`=1, `win`=0, `winner`=00.
- Illegal cases:
  - player to occupied cell 4 → pulse, cell 4 stays 01;
  - address 9 → pulse;
  - both requests on the same edge → pulse, `board` unchanged;
  - request while `busy` → pulse.
- N=5, K=4, macro on.
  - Computer fills 4, 8, 12, 16 (down-left diagonal) alternating with player 0, 1, 2, 3. Required: `win`=1, `winner`=10 after 25 scan cycles.
  - A second consecutive player move → pulse.
- Assert `rstn` low during SCAN. Required: immediate reset values; the next move is accepted normally.
